// File: rtl/apu_multi_voice.sv
// apu_multi_voice: raster-timed audio unit.
//   NUM_VOICES square-wave voices play a fixed note table, one sequencer
//   step every STEP_FRAMES frames. Each voice has a decaying envelope.
//   A 13-bit LFSR noise channel plays one-shot effects on sfx_trigger.
//   All levels are summed and sent out through a first-order sigma-delta.
// Ports:
//   clk, rst_n           pixel clock, asynchronous active-low reset
//   hpos, vpos           raster position (line tick = hpos==0, frame tick = both 0)
//   bgm_ena              music run / pause (paused voices are silent)
//   voice_mute           per-voice mute
//   sfx_trigger          rising edge starts or restarts the noise effect
//   sfx_busy             noise effect sounding
//   step_idx             current sequencer step
//   audio_out            sigma-delta bitstream
//   amp_en               amplifier enable, high from one clk after reset release
module apu_multi_voice #(
  parameter int unsigned NUM_VOICES  = 3,
  parameter int unsigned PER_W       = 9,
  parameter int unsigned ENV_W       = 5,
  parameter int unsigned SEQ_DEPTH   = 16,
  parameter int unsigned STEP_FRAMES = 16,
  parameter int unsigned SFX_LEN     = 24,
  parameter int unsigned NOISE_DIV   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [9:0]                   hpos,
  input  logic [9:0]                   vpos,
  input  logic                         bgm_ena,
  input  logic [NUM_VOICES-1:0]        voice_mute,
  input  logic                         sfx_trigger,
  output logic                         sfx_busy,
  output logic [$clog2(SEQ_DEPTH)-1:0] step_idx,
  output logic                         audio_out,
  output logic                         amp_en
);

  localparam int unsigned STEP_W = $clog2(SEQ_DEPTH);
  localparam int unsigned FC_W   = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam int unsigned LEN_W  = $clog2(SFX_LEN + 1);
  localparam int unsigned DIV_W  = (NOISE_DIV > 1) ? $clog2(NOISE_DIV) : 1;
  localparam int unsigned MIX_W  = ENV_W + $clog2(NUM_VOICES + 2);

  localparam logic [ENV_W-1:0] ENV_MAX = '1;
  localparam logic [PER_W-1:0] REST    = '1;

  // Note tables (line ticks per half period minus one); 511 marks a rest.
  localparam int unsigned LEAD_TAB [16] = '{191, 170, 151, 143, 127, 143, 151, 170,
                                            191, 511, 151, 127, 113, 127, 151, 191};
  localparam int unsigned BASS_TAB [16] = '{382, 382, 339, 511, 382, 382, 302, 511,
                                            339, 339, 285, 511, 382, 339, 302, 511};
  localparam int unsigned HARM_TAB [16] = '{127, 113, 511, 101,  95, 101, 113, 127,
                                            151, 511, 113,  95,  85,  95, 113, 127};

  function automatic logic [PER_W-1:0] note_period(input int unsigned v, input logic [3:0] idx);
    int unsigned raw;
    case (v)
      0:       raw = LEAD_TAB[idx];
      1:       raw = BASS_TAB[idx];
      default: raw = HARM_TAB[idx];
    endcase
    return (raw >= 511) ? REST : PER_W'(raw);
  endfunction

  // Ticks
  logic line_tick, frame_tick;
  always_comb begin
    line_tick  = (hpos == '0);
    frame_tick = line_tick && (vpos == '0);
  end

  // Sequencer
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              first_q, first_d;
  logic              step_adv, voice_reload;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    step_d      = step_q;
    step_adv    = frame_tick && bgm_ena && (frame_cnt_q == FC_W'(STEP_FRAMES - 1));
    if (frame_tick && bgm_ena) begin
      if (step_adv) begin
        frame_cnt_d = '0;
        step_d      = (step_q == STEP_W'(SEQ_DEPTH - 1)) ? '0 : step_q + STEP_W'(1);
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
    end
    first_d      = first_q && !frame_tick;
    // Voices restart on every step change and once on the first frame after reset.
    voice_reload = frame_tick && (first_q || step_adv);
  end

  // Voices
  logic [PER_W-1:0] cnt_q [NUM_VOICES];
  logic [PER_W-1:0] cnt_d [NUM_VOICES];
  logic [ENV_W-1:0] env_q [NUM_VOICES];
  logic [ENV_W-1:0] env_d [NUM_VOICES];
  logic [ENV_W-1:0] level [NUM_VOICES];
  logic [PER_W-1:0] period [NUM_VOICES];
  logic [NUM_VOICES-1:0] wave_q, wave_d;
  logic [3:0] tab_idx;

  always_comb begin
    tab_idx = 4'(step_q);
    wave_d  = wave_q;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      period[v] = note_period(v, tab_idx);
      cnt_d[v]  = cnt_q[v];
      env_d[v]  = env_q[v];
      if (voice_reload) begin
        cnt_d[v]  = '0;
        wave_d[v] = 1'b0;
        env_d[v]  = ENV_MAX;
      end else begin
        if (frame_tick && (env_q[v] != '0)) env_d[v] = env_q[v] - ENV_W'(1);
        if (period[v] == REST) begin
          cnt_d[v]  = '0;
          wave_d[v] = 1'b0;
        end else if (line_tick) begin
          if (cnt_q[v] >= period[v]) begin
            cnt_d[v]  = '0;
            wave_d[v] = ~wave_q[v];
          end else begin
            cnt_d[v] = cnt_q[v] + PER_W'(1);
          end
        end
      end
      level[v] = (wave_q[v] && !voice_mute[v] && bgm_ena) ? env_q[v] : '0;
    end
  end

  // Noise effect
  logic              trig_prev_q, trig_prev_d;
  logic              busy_q, busy_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ENV_W-1:0]  nenv_q, nenv_d;
  logic [DIV_W-1:0]  ndiv_q, ndiv_d;
  logic [12:0]       lfsr_q, lfsr_d;
  logic              trig_edge, lfsr_fb;
  logic [ENV_W-1:0]  noise_level;

  always_comb begin
    trig_prev_d = sfx_trigger;
    trig_edge   = sfx_trigger && !trig_prev_q;
    busy_d      = busy_q;
    len_d       = len_q;
    nenv_d      = nenv_q;
    ndiv_d      = ndiv_q;
    lfsr_d      = lfsr_q;
    lfsr_fb     = lfsr_q[12] ^ lfsr_q[3] ^ lfsr_q[2] ^ lfsr_q[0];
    // A trigger edge takes priority over a coincident frame tick.
    if (trig_edge) begin
      len_d  = LEN_W'(SFX_LEN);
      nenv_d = ENV_MAX;
      busy_d = 1'b1;
      ndiv_d = '0;
    end else if (busy_q) begin
      if (line_tick) begin
        if (ndiv_q == DIV_W'(NOISE_DIV - 1)) begin
          ndiv_d = '0;
          lfsr_d = {lfsr_q[11:0], lfsr_fb};
        end else begin
          ndiv_d = ndiv_q + DIV_W'(1);
        end
      end
      if (frame_tick) begin
        len_d = len_q - LEN_W'(1);
        if (nenv_q != '0) nenv_d = nenv_q - ENV_W'(1);
        if (len_q == LEN_W'(1)) busy_d = 1'b0;
      end
    end
    noise_level = (busy_q && lfsr_q[0]) ? nenv_q : '0;
  end

  // Mixer and sigma-delta: the carry out of acc+mix is the output bit.
  logic [MIX_W-1:0] mix, acc_q, acc_d;
  logic [MIX_W:0]   sum_w;
  logic             audio_q, audio_d;
  logic             amp_en_q, amp_en_d;

  always_comb begin
    mix = MIX_W'(noise_level);
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      mix = mix + MIX_W'(level[v]);
    end
    sum_w    = {1'b0, acc_q} + {1'b0, mix};
    acc_d    = sum_w[MIX_W-1:0];
    audio_d  = sum_w[MIX_W];
    amp_en_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      step_q      <= '0;
      first_q     <= 1'b1;
      wave_q      <= '0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        cnt_q[v] <= '0;
        env_q[v] <= '0;
      end
      trig_prev_q <= 1'b0;
      busy_q      <= 1'b0;
      len_q       <= '0;
      nenv_q      <= '0;
      ndiv_q      <= '0;
      lfsr_q      <= '1;
      acc_q       <= '0;
      audio_q     <= 1'b0;
      amp_en_q    <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      step_q      <= step_d;
      first_q     <= first_d;
      wave_q      <= wave_d;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        cnt_q[v] <= cnt_d[v];
        env_q[v] <= env_d[v];
      end
      trig_prev_q <= trig_prev_d;
      busy_q      <= busy_d;
      len_q       <= len_d;
      nenv_q      <= nenv_d;
      ndiv_q      <= ndiv_d;
      lfsr_q      <= lfsr_d;
      acc_q       <= acc_d;
      audio_q     <= audio_d;
      amp_en_q    <= amp_en_d;
    end
  end

  always_comb begin
    sfx_busy  = busy_q;
    step_idx  = step_q;
    audio_out = audio_q;
    amp_en    = amp_en_q;
  end

endmodule

// File: tb/tb_apu_multi_voice.sv
module tb_apu_multi_voice;

  localparam int NV   = 3;
  localparam int SD   = 4;
  localparam int SF   = 2;
  localparam int SL   = 24;
  localparam int ND   = 2;
  localparam int H    = 4;
  localparam int V    = 128;
  localparam int EMAX = 31;
  localparam int REST = 511;
  localparam int MIXM = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] hpos = '0;
  logic [9:0] vpos = '0;
  logic       bgm_ena = 1'b0;
  logic [2:0] voice_mute = '0;
  logic       sfx_trigger = 1'b0;
  logic       sfx_busy;
  logic [1:0] step_idx;
  logic       audio_out;
  logic       amp_en;

  always #5 clk = ~clk;

  apu_multi_voice #(
    .NUM_VOICES (NV),
    .PER_W      (9),
    .ENV_W      (5),
    .SEQ_DEPTH  (SD),
    .STEP_FRAMES(SF),
    .SFX_LEN    (SL),
    .NOISE_DIV  (ND)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hpos       (hpos),
    .vpos       (vpos),
    .bgm_ena    (bgm_ena),
    .voice_mute (voice_mute),
    .sfx_trigger(sfx_trigger),
    .sfx_busy   (sfx_busy),
    .step_idx   (step_idx),
    .audio_out  (audio_out),
    .amp_en     (amp_en)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: voice waves derived from line ticks elapsed since the last restart,
  // sequencer step derived from the number of enabled frames.
  int tab [NV][SD] = '{'{191, 170, 151, 143}, '{382, 382, 339, 511}, '{127, 113, 511, 101}};
  int en_frames, first, prev, busy, left, nenv, nlines, lfsr, acc, audio, amp;
  int lines [NV];
  int env   [NV];
  bit last_ft;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mstep();
    return (en_frames / SF) % SD;
  endfunction

  function automatic int wave_of(input int v);
    int p;
    p = tab[v][mstep()];
    if (p == REST) return 0;
    return (lines[v] / (p + 1)) % 2;
  endfunction

  task automatic model_reset();
    en_frames = 0; first = 1; prev = 0; busy = 0; left = 0; nenv = 0;
    nlines = 0; lfsr = 8191; acc = 0; audio = 0; amp = 0;
    for (int v = 0; v < NV; v++) begin
      lines[v] = 0;
      env[v]   = 0;
    end
  endtask

  task automatic model_step();
    int mix, ft, lt, reload, edge_seen, fb, p;
    lt  = (hpos == 0);
    ft  = lt && (vpos == 0);
    mix = 0;
    for (int v = 0; v < NV; v++)
      if (wave_of(v) == 1 && !voice_mute[v] && bgm_ena) mix += env[v];
    if (busy && (lfsr % 2 == 1)) mix += nenv;
    audio = (acc + mix) >= MIXM;
    acc   = (acc + mix) % MIXM;

    reload = 0;
    if (ft && bgm_ena) begin
      en_frames++;
      if (en_frames % SF == 0) reload = 1;
    end
    if (ft && first) reload = 1;
    if (ft) first = 0;
    for (int v = 0; v < NV; v++) begin
      if (reload) begin
        lines[v] = 0;
        env[v]   = EMAX;
      end else begin
        p = tab[v][mstep()];
        if (ft && env[v] > 0) env[v]--;
        if (p != REST && lt) lines[v]++;
      end
    end

    edge_seen = sfx_trigger && !prev;
    prev      = sfx_trigger;
    if (edge_seen) begin
      left = SL; nenv = EMAX; busy = 1; nlines = 0;
    end else if (busy) begin
      if (lt) begin
        nlines++;
        if (nlines % ND == 0) begin
          fb   = ((lfsr >> 12) ^ (lfsr >> 3) ^ (lfsr >> 2) ^ lfsr) & 1;
          lfsr = ((lfsr << 1) | fb) & 8191;
        end
      end
      if (ft) begin
        left--;
        if (nenv > 0) nenv--;
        if (left == 0) busy = 0;
      end
    end
    amp = 1;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_audio_out"}, audio_out, audio);
    chk({tag, "_sfx_busy"},  sfx_busy,  busy);
    chk({tag, "_step_idx"},  step_idx,  rst_n ? mstep() : 0);
    chk({tag, "_amp_en"},    amp_en,    amp);
  endtask

  task automatic cyc();
    last_ft = (hpos == 0) && (vpos == 0);
    @(posedge clk);
    #1;
    if (rst_n) model_step();
    else       model_reset();
    check_outputs("cyc");
    if (hpos == 10'(H - 1)) begin
      hpos = '0;
      vpos = (vpos == 10'(V - 1)) ? '0 : vpos + 10'd1;
    end else begin
      hpos = hpos + 10'd1;
    end
  endtask

  task automatic align();
    int b;
    b = H * V + 1;
    while (!(hpos == 0 && vpos == 0) && b > 0) begin
      cyc();
      b--;
    end
  endtask

  task automatic run_frames(input int n);
    repeat (n * H * V) cyc();
  endtask

  // Triggers an effect and counts frame ticks until sfx_busy falls.
  task automatic run_sfx(input int retrig_at, input bit coincide, output int count);
    int budget;
    bit done;
    count = 0;
    done  = 0;
    if (coincide) align();
    sfx_trigger = 1'b1;
    cyc();
    sfx_trigger = 1'b0;
    chk("sfx_busy_rise", sfx_busy, 1);
    budget = 50 * H * V;
    while (budget > 0 && !done) begin
      cyc();
      budget--;
      if (last_ft) count++;
      if (!sfx_busy) done = 1;
      else if (retrig_at > 0 && last_ft && count == retrig_at) begin
        sfx_trigger = 1'b1;
        cyc();
        sfx_trigger = 1'b0;
        budget--;
      end
    end
    if (!done) chk("sfx_timeout", 0, 1);
  endtask

  typedef struct {
    bit bgm;
    int frames;
    int exp_step;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int cnt;
    int ones;
    vecs[0]  = '{1'b1, 1, 0};
    vecs[1]  = '{1'b1, 1, 1};
    vecs[2]  = '{1'b1, 1, 1};
    vecs[3]  = '{1'b1, 1, 2};
    vecs[4]  = '{1'b1, 1, 2};
    vecs[5]  = '{1'b1, 1, 3};
    vecs[6]  = '{1'b1, 1, 3};
    vecs[7]  = '{1'b1, 1, 0};
    vecs[8]  = '{1'b0, 3, 0};
    vecs[9]  = '{1'b1, 1, 0};
    vecs[10] = '{1'b1, 1, 1};

    model_reset();

    // Reset held with the raster sweeping.
    repeat (20) cyc();
    chk("reset_amp_en", amp_en, 0);
    chk("reset_step_idx", step_idx, 0);
    rst_n = 1'b1;
    cyc();
    chk("amp_en_release", amp_en, 1);

    // Sequencer stepping and freezing.
    align();
    foreach (vecs[i]) begin
      bgm_ena = vecs[i].bgm;
      run_frames(vecs[i].frames);
      chk($sformatf("step_tab%0d", i), step_idx, vecs[i].exp_step);
    end

    // Lead alone, then all voices.
    voice_mute = 3'b110;
    run_frames(4);
    voice_mute = 3'b000;
    run_frames(2);

    // Noise effect length, re-trigger, and trigger coinciding with a frame tick.
    run_sfx(0, 1'b0, cnt);
    chk("sfx_len", cnt, SL);
    run_sfx(10, 1'b0, cnt);
    chk("sfx_retrig_len", cnt, 34);
    sfx_trigger = 1'b1;
    cyc();
    sfx_trigger = 1'b0;
    run_frames(5);
    run_sfx(0, 1'b1, cnt);
    chk("sfx_coincide_len", cnt, SL);

    // Silent mix keeps the output low.
    bgm_ena = 1'b0;
    ones = 0;
    repeat (H * V) begin
      cyc();
      if (audio_out) ones++;
    end
    chk("mix0_audio", ones, 0);

    // Randomised inputs.
    bgm_ena = 1'b1;
    repeat (4 * H * V) begin
      if ($urandom_range(0, 63) == 0)  voice_mute = 3'($urandom);
      if ($urandom_range(0, 511) == 0) bgm_ena = ~bgm_ena;
      if ($urandom_range(0, 299) == 0) sfx_trigger = ~sfx_trigger;
      cyc();
    end

    // Reset in the middle of an effect and a note.
    bgm_ena = 1'b1;
    sfx_trigger = 1'b0;
    cyc();
    sfx_trigger = 1'b1;
    cyc();
    run_frames(2);
    chk("pre_reset_busy", sfx_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    sfx_trigger = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_step", step_idx, 0);
    chk("post_rst_busy", sfx_busy, 0);
    chk("post_rst_amp_en", amp_en, 1);
    run_frames(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
